// File: rtl/pe_tile_scheduler_if.sv
// PE-side tile handshake bundle for pe_tile_scheduler: tile offer (valid/indices)
// towards the PE, ready and result-return back from it.
interface pe_tile_scheduler_if;
  // A tile moves on a rising edge where data_valid_o and pe_ready_i are both high;
  // while valid is high without ready, indices and size type hold steady.
  // result_valid_i is a one-cycle pulse per finished tile, independent of valid.
  logic       data_valid_o;
  logic       weight_valid_o;
  logic [8:0] data_x_index_o;
  logic [8:0] data_y_index_o;
  logic [7:0] weight_od_o;
  logic       weight_size_type_o;
  logic       pe_ready_i;
  logic       result_valid_i;

  modport master (
    output data_valid_o, weight_valid_o, data_x_index_o, data_y_index_o,
    output weight_od_o, weight_size_type_o,
    input  pe_ready_i, result_valid_i
  );

  modport slave (
    input  data_valid_o, weight_valid_o, data_x_index_o, data_y_index_o,
    input  weight_od_o, weight_size_type_o,
    output pe_ready_i, result_valid_i
  );
endinterface

// File: rtl/pe_tile_scheduler.sv
// Walks an x/y/od tile space, offering tiles to a PE under an outstanding-result limit.
// Optional SCHED_STALL_CNT_EN adds a saturating stall counter output (stall_cnt_o).
module pe_tile_scheduler #(
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [8:0]           cfg_x_tiles_i,
  input  logic [8:0]           cfg_y_tiles_i,
  input  logic [7:0]           cfg_od_i,
  input  logic                 cfg_size_type_i,
  pe_tile_scheduler_if.master  pe,
`ifdef SCHED_STALL_CNT_EN
  output logic [15:0]          stall_cnt_o,
`endif
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] cfg_x_q, cfg_y_q, x_q, y_q;
  logic [7:0] cfg_od_q, od_q;
  logic       size_q;
  logic [7:0] out_q, out_d;
  logic       err_q;

  logic valid, xfer, x_last, y_last, od_last, tile_last, start_acc, cfg_zero;

  assign valid     = (state_q == ISSUE) && (out_q < 8'(MAX_OUTSTANDING));
  assign xfer      = valid && pe.pe_ready_i;
  assign x_last    = (x_q == cfg_x_q - 9'd1);
  assign y_last    = (y_q == cfg_y_q - 9'd1);
  assign od_last   = (od_q == cfg_od_q - 8'd1);
  assign tile_last = x_last && y_last && od_last;
  assign start_acc = (state_q == IDLE) && start_i;
  assign cfg_zero  = (cfg_x_tiles_i == 9'd0) || (cfg_y_tiles_i == 9'd0) || (cfg_od_i == 8'd0);

  // A transfer and a result in the same cycle cancel; an unmatched result at zero is dropped.
  always_comb begin
    out_d = out_q;
    case ({xfer, pe.result_valid_i})
      2'b10:   out_d = out_q + 8'd1;
      2'b01:   if (out_q != 8'd0) out_d = out_q - 8'd1;
      default: out_d = out_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = cfg_zero ? DONE : ISSUE;
      ISSUE:   if (xfer && tile_last) state_d = DRAIN;
      DRAIN:   if (out_d == 8'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cfg_x_q  <= '0;
      cfg_y_q  <= '0;
      cfg_od_q <= '0;
      size_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      od_q     <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      if (pe.result_valid_i && !xfer && (out_q == 8'd0)) err_q <= 1'b1;
      if (start_acc) begin
        cfg_x_q  <= cfg_x_tiles_i;
        cfg_y_q  <= cfg_y_tiles_i;
        cfg_od_q <= cfg_od_i;
        size_q   <= cfg_size_type_i;
        x_q      <= '0;
        y_q      <= '0;
        od_q     <= '0;
      end else if (xfer) begin
        // x innermost, then y, then od; the final tile wraps everything back to 0.
        if (x_last) begin
          x_q <= '0;
          if (y_last) begin
            y_q  <= '0;
            od_q <= od_last ? 8'd0 : od_q + 8'd1;
          end else begin
            y_q <= y_q + 9'd1;
          end
        end else begin
          x_q <= x_q + 9'd1;
        end
      end
    end
  end

`ifdef SCHED_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      stall_q <= '0;
    end else if ((state_q == ISSUE) && !xfer && (stall_q != 16'hffff)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

  assign pe.data_valid_o       = valid;
  assign pe.weight_valid_o     = valid;
  assign pe.data_x_index_o     = x_q;
  assign pe.data_y_index_o     = y_q;
  assign pe.weight_od_o        = od_q;
  assign pe.weight_size_type_o = size_q;
  assign busy_o                = (state_q != IDLE);
  assign done_o                = (state_q == DONE);
  assign err_o                 = err_q;
  assign dbg_state_o           = state_q;

endmodule

// File: doc/pe_tile_scheduler.md
PE_TILE_SCHEDULER -- requirements
Module: pe_tile_scheduler

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 16, range 1..255: maximum tiles issued to the PE without a returned result.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start_i  in  1  one-cycle request to begin a job; sampled only in IDLE.
REQ-005 cfg_x_tiles_i  in  9  tile columns per job.
REQ-006 cfg_y_tiles_i  in  9  tile rows per job.
REQ-007 cfg_od_i  in  8  output depths per job.
REQ-008 cfg_size_type_i  in  1  filter-size type forwarded to the PE.
REQ-009 pe_ready_i  in  1  PE accepts the current tile.
REQ-010 result_valid_i  in  1  PE returned one result tile.
REQ-011 data_valid_o / weight_valid_o  out  1 each  tile offered to the PE; always equal.
REQ-012 data_x_index_o  out  9  current tile column.
REQ-013 data_y_index_o  out  9  current tile row.
REQ-014 weight_od_o  out  8  current output depth.
REQ-015 weight_size_type_o  out  1  latched cfg_size_type_i.
REQ-016 busy_o  out  1  high in every state except IDLE.
REQ-017 done_o  out  1  one-cycle pulse at job completion.
REQ-018 err_o  out  1  sticky: result_valid_i received while outstanding count is 0.

Function
REQ-019 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-020 IDLE -> ISSUE on start_i; cfg inputs latched that cycle; x, y, od counters cleared to 0.
REQ-021 IDLE -> DONE on start_i when any latched tile count is 0; no tile is issued.
REQ-022 start_i outside IDLE is ignored; latched config does not change.
REQ-023 valid_o = (state == ISSUE) and (outstanding < MAX_OUTSTANDING).
REQ-024 Transfer = valid_o and pe_ready_i; indices remain stable until a transfer occurs.
REQ-025 Issue order: x innermost, then y, then od; each wraps to 0 on reaching its count - 1 and carries to the next counter.
REQ-026 ISSUE -> DRAIN on the transfer of the last tile (x, y, od each at count - 1).
REQ-027 Outstanding counter (8 bits): +1 on transfer, -1 on result_valid_i, unchanged when both occur in one cycle.
REQ-028 result_valid_i with outstanding 0 and no same-cycle transfer: counter stays 0; err_o set.
REQ-029 DRAIN -> DONE when outstanding is 0 (including a same-cycle final decrement).
REQ-030 DONE: done_o high for exactly 1 cycle, then IDLE.
REQ-031 Transfer to the PE requires at least 1 cycle after start_i; first valid_o is in the cycle after start_i.

Reset
REQ-032 reset overrides all inputs, including mid-job: state becomes IDLE.
REQ-033 On reset, outstanding and counters are cleared to 0.
REQ-034 On reset, all outputs and latched config are cleared to 0; err_o is cleared.

Configuration
REQ-035 Macro SCHED_STALL_CNT_EN, when defined, adds output stall_cnt_o (16 bits, saturating).
REQ-036 stall_cnt_o counts cycles in ISSUE without a transfer; it clears on start_i accept and on reset.
REQ-037 With SCHED_STALL_CNT_EN undefined, the port and counter do not exist; all other behaviour is identical.

Verification
REQ-038 cfg 2x2x1, pe_ready_i=1, result returned 3 cycles after each transfer -> (x,y) sequence (0,0),(1,0),(0,1),(1,1), od 0; then done_o pulses once.
REQ-039 cfg 3x1x2, pe_ready_i low on alternate cycles -> indices held while ready is low; od goes 0 then 1; exactly 6 transfers.
REQ-040 MAX_OUTSTANDING=2, no results for 10 cycles -> valid_o drops after 2 transfers; it resumes the cycle after the first result_valid_i.
REQ-041 cfg_x_tiles_i=0 -> DONE the cycle after start_i; zero transfers.
REQ-042 reset asserted after 2 of 4 transfers -> next cycle IDLE, all outputs 0; a new start_i runs a full job from (0,0,0).
REQ-043 result_valid_i in IDLE -> err_o=1 and remains 1 until reset; with SCHED_STALL_CNT_EN defined, REQ-039 gives stall_cnt_o equal to the ready-low cycles in ISSUE.
